dphy_delay_calib: RTL and testbench

DPHY_DELAY_CALIB -- requirements
Module: dphy_delay_calib

---
 rtl/dphy_calib_pkg.sv | 26 ++
 rtl/dphy_eye_tracker.sv | 49 ++++
 rtl/dphy_delay_calib.sv | 174 +++++++++++++++++
 tb/tb_dphy_delay_calib.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dphy_calib_pkg.sv
// Shared definitions for the D-PHY lane delay calibration block:
// default training constants, FSM state type and the eye-centre helper.
package dphy_calib_pkg;

  localparam logic [7:0] DEF_PATTERN = 8'hB8;
  localparam int         DEF_SAMPLES = 256;
  localparam int         DEF_SETTLE  = 8;
  localparam int         DEF_MIN_EYE = 3;
  localparam int         NUM_TAPS    = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PARK,
    ST_SETTLE,
    ST_SAMPLE,
    ST_STEP,
    ST_ALIGN,
    ST_DONE
  } calib_state_t;

  // The sum stays 6 bits wide; start + len never exceeds 32, so the centre fits in 0..31.
  function automatic logic [5:0] eye_center(input logic [4:0] start, input logic [5:0] len);
    return {1'b0, start} + {1'b0, len[5:1]};
  endfunction

endpackage

// File: rtl/dphy_eye_tracker.sv
// Tracks the current run of passing taps and remembers the longest one seen,
// the earliest run winning a tie; runs are closed at tap 31 and never wrap.
module dphy_eye_tracker
  import dphy_calib_pkg::*;
(
  input  logic       byte_clk_i,
  input  logic       rst_i,
  input  logic       clear,
  input  logic       eval,
  input  logic       pass,
  input  logic [4:0] tap,
  output logic [4:0] best_start,
  output logic [5:0] best_len
);

  logic [4:0] run_start;
  logic [5:0] run_len;
  logic [5:0] len_now;
  logic [4:0] start_now;
  logic       run_ends;

  always_comb begin
    len_now   = pass ? run_len + 6'd1 : run_len;
    start_now = (pass && run_len == 6'd0) ? tap : run_start;
    run_ends  = !pass || (tap == 5'(NUM_TAPS - 1));
  end

  always_ff @(posedge byte_clk_i) begin
    if (rst_i || clear) begin
      run_start  <= '0;
      run_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (eval) begin
      if (run_ends) begin
        run_start <= '0;
        run_len   <= '0;
        if (len_now > best_len) begin
          best_len   <= len_now;
          best_start <= start_now;
        end
      end else begin
        run_len   <= len_now;
        run_start <= start_now;
      end
    end
  end

endmodule

// File: rtl/dphy_delay_calib.sv
// Sweeps the lane IDELAY over all 32 taps while comparing the training byte,
// then steps the delay to the centre of the widest passing eye.
module dphy_delay_calib
  import dphy_calib_pkg::*;
#(
  parameter logic [7:0] PATTERN = DEF_PATTERN,
  parameter int         SAMPLES = DEF_SAMPLES,
  parameter int         SETTLE  = DEF_SETTLE,
  parameter int         MIN_EYE = DEF_MIN_EYE
) (
  input  logic       byte_clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] byte_data_i,
  input  logic       byte_valid_i,
  input  logic [4:0] cur_delay_i,
  output logic       inc_delay_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       fail_o,
  output logic [4:0] best_delay_o,
  output logic [5:0] eye_width_o
);

  localparam int            SW          = $clog2(SAMPLES);
  localparam int            TW          = $clog2(SETTLE + 2);
  localparam logic [SW-1:0] LAST_SAMPLE = SW'(SAMPLES - 1);
  localparam logic [TW-1:0] WAIT_FULL   = TW'(SETTLE);
  localparam logic [TW-1:0] WAIT_M1     = TW'(SETTLE - 1);
  localparam logic [5:0]    MIN_LEN     = 6'(MIN_EYE);
  localparam logic [4:0]    LAST_TAP    = 5'(NUM_TAPS - 1);

  calib_state_t  state, state_next;
  logic [TW-1:0] timer;
  logic [4:0]    tap_idx;
  logic [SW-1:0] sample_cnt;
  logic          mismatch;
  logic          tap_pass;
  logic          inc;
  logic          last_byte;
  logic          byte_bad;
  logic [4:0]    best_start;
  logic [5:0]    best_len;
  logic [5:0]    center;
  logic          eye_too_small;

  assign last_byte     = byte_valid_i && (sample_cnt == LAST_SAMPLE);
  assign byte_bad      = (byte_data_i != PATTERN);
  assign center        = eye_center(best_start, best_len);
  assign eye_too_small = (best_len < MIN_LEN);

  dphy_eye_tracker u_tracker (
    .byte_clk_i (byte_clk_i),
    .rst_i      (rst_i),
    .clear      (state == ST_IDLE && start_i),
    .eval       (state == ST_STEP),
    .pass       (tap_pass),
    .tap        (tap_idx),
    .best_start (best_start),
    .best_len   (best_len)
  );

  always_ff @(posedge byte_clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Every increment is issued only once the wait timer has run out, which keeps pulses SETTLE apart.
  always_comb begin
    state_next = state;
    inc        = 1'b0;
    case (state)
      ST_IDLE:   if (start_i) state_next = ST_PARK;
      ST_PARK: begin
        if (timer == '0) begin
          if (cur_delay_i == 5'd0) state_next = ST_SETTLE;
          else                     inc        = 1'b1;
        end
      end
      ST_SETTLE: if (timer == '0) state_next = ST_SAMPLE;
      ST_SAMPLE: if (last_byte) state_next = ST_STEP;
      ST_STEP: begin
        inc        = 1'b1;
        state_next = (tap_idx == LAST_TAP) ? ST_ALIGN : ST_SETTLE;
      end
      ST_ALIGN: begin
        if (eye_too_small) begin
          state_next = ST_IDLE;
        end else if (timer == '0) begin
          if ({1'b0, cur_delay_i} == center) state_next = ST_DONE;
          else                               inc        = 1'b1;
        end
      end
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign inc_delay_o = inc;
  assign busy_o      = (state != ST_IDLE) && (state != ST_DONE);
  assign done_o      = (state == ST_DONE);

  always_ff @(posedge byte_clk_i) begin
    if (rst_i) begin
      timer      <= '0;
      tap_idx    <= '0;
      sample_cnt <= '0;
      mismatch   <= 1'b0;
      tap_pass   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          timer   <= '0;
          tap_idx <= '0;
        end
        ST_PARK: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (cur_delay_i == 5'd0) begin
            timer   <= WAIT_M1;
            tap_idx <= '0;
          end else begin
            timer <= WAIT_FULL;
          end
        end
        ST_SETTLE: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            sample_cnt <= '0;
            mismatch   <= 1'b0;
          end
        end
        ST_SAMPLE: begin
          if (byte_valid_i) begin
            sample_cnt <= sample_cnt + 1'b1;
            mismatch   <= mismatch | byte_bad;
            if (last_byte) tap_pass <= !(mismatch || byte_bad);
          end
        end
        ST_STEP: begin
          timer   <= (tap_idx == LAST_TAP) ? WAIT_FULL : WAIT_M1;
          tap_idx <= tap_idx + 5'd1;
        end
        ST_ALIGN: begin
          if (timer != '0) timer <= timer - 1'b1;
          else if (inc)    timer <= WAIT_FULL;
        end
        default: ;
      endcase
    end
  end

  // Results are cleared on a new request and held after completion until the next one.
  always_ff @(posedge byte_clk_i) begin
    if (rst_i) begin
      fail_o       <= 1'b0;
      best_delay_o <= '0;
      eye_width_o  <= '0;
    end else if (state == ST_IDLE && start_i) begin
      fail_o       <= 1'b0;
      best_delay_o <= '0;
      eye_width_o  <= '0;
    end else if (state == ST_ALIGN && eye_too_small) begin
      fail_o       <= 1'b1;
      best_delay_o <= '0;
      eye_width_o  <= best_len;
    end else if (state == ST_ALIGN && state_next == ST_DONE) begin
      best_delay_o <= center[4:0];
      eye_width_o  <= best_len;
    end
  end

endmodule

// File: tb/tb_dphy_delay_calib.sv
// Directed bench: an IDELAY tap model plus a lane that sends the training
// byte cleanly only on chosen taps, checked against a longest-run model.
module tb_dphy_delay_calib;

  localparam logic [7:0] TB_PATTERN = 8'hB8;
  localparam int         TB_SAMPLES = 16;
  localparam int         TB_SETTLE  = 4;
  localparam int         TB_MIN_EYE = 3;

  localparam logic [31:0] MASK_A = 32'h000F_FC00;
  localparam logic [31:0] MASK_B = 32'h00F0_003C;
  localparam logic [31:0] MASK_C = 32'hC000_0003;
  localparam logic [31:0] MASK_D = 32'hFFFF_FFFF;

  logic       byte_clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [7:0] byte_data_i;
  logic       byte_valid_i;
  logic [4:0] cur_delay_i;
  logic       inc_delay_o;
  logic       busy_o;
  logic       done_o;
  logic       fail_o;
  logic [4:0] best_delay_o;
  logic [5:0] eye_width_o;

  dphy_delay_calib #(
    .PATTERN (TB_PATTERN),
    .SAMPLES (TB_SAMPLES),
    .SETTLE  (TB_SETTLE),
    .MIN_EYE (TB_MIN_EYE)
  ) dut (
    .byte_clk_i   (byte_clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .byte_data_i  (byte_data_i),
    .byte_valid_i (byte_valid_i),
    .cur_delay_i  (cur_delay_i),
    .inc_delay_o  (inc_delay_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .fail_o       (fail_o),
    .best_delay_o (best_delay_o),
    .eye_width_o  (eye_width_o)
  );

  always #5 byte_clk_i = ~byte_clk_i;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_inc = -100;
  int          pulse_cnt = 0;
  int          park_cnt = 0;
  int          done_cnt = 0;
  bit          parked = 1'b0;
  int          exp_best = 0;
  int          exp_eye = 0;
  logic [4:0]  tap;
  logic        load_tap = 1'b1;
  logic [4:0]  load_val = 5'd0;
  logic [31:0] pass_mask = 32'h0;
  bit          toggle_valid = 1'b0;
  bit          phase = 1'b0;
  int          byte_cnt = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Longest run of consecutive passing taps inside 0..31, earliest on a tie.
  function automatic void model_eye(input logic [31:0] mask, output int start, output int len);
    int cur;
    int s;
    cur = 0; s = 0; start = 0; len = 0;
    for (int i = 0; i < 32; i++) begin
      if (mask[i]) begin
        cur++;
        if (cur == 1) s = i;
        if (cur > len) begin
          len   = cur;
          start = s;
        end
      end else begin
        cur = 0;
      end
    end
  endfunction

  // IDELAY model: one tap per increment pulse, wrapping 31 -> 0.
  always @(posedge byte_clk_i) begin
    if (load_tap)         tap <= load_val;
    else if (inc_delay_o) tap <= tap + 5'd1;
  end
  assign cur_delay_i = tap;

  // Lane model: failing taps corrupt every third valid byte.
  always @(negedge byte_clk_i) begin
    phase        = ~phase;
    byte_valid_i = toggle_valid ? phase : 1'b1;
    if (byte_valid_i) byte_cnt++;
    byte_data_i = (pass_mask[tap] || (byte_cnt % 3 != 0)) ? TB_PATTERN : (TB_PATTERN ^ 8'h40);
  end

  // Per-cycle compare against the model expectations.
  always @(negedge byte_clk_i) begin
    cyc++;
    if (tap == 5'd0) parked = 1'b1;
    if (!rst_i && inc_delay_o) begin
      checkOutput("inc_spacing", int'(cyc - last_inc > TB_SETTLE), 1);
      last_inc = cyc;
      pulse_cnt++;
      if (!parked) park_cnt++;
    end
    if (done_o) begin
      done_cnt++;
      checkOutput("done_best_delay", best_delay_o, exp_best);
      checkOutput("done_eye_width", eye_width_o, exp_eye);
      checkOutput("done_busy", busy_o, 0);
    end
  end

  task automatic applyStimulus(input logic [31:0] mask, input bit tog, input int init_tap,
                               output int cycles);
    int  s, l, start_tap, ctr, exp_pulses;
    bit  exp_fail;
    model_eye(mask, s, l);
    exp_fail = (l < TB_MIN_EYE);
    ctr      = exp_fail ? 0 : s + l / 2;
    exp_best = exp_fail ? 0 : ctr;
    exp_eye  = l;
    pass_mask    = mask;
    toggle_valid = tog;
    if (init_tap >= 0) begin
      @(negedge byte_clk_i);
      load_val = 5'(init_tap);
      load_tap = 1'b1;
      @(negedge byte_clk_i);
      load_tap = 1'b0;
    end
    start_tap = int'(tap);
    pulse_cnt = 0; park_cnt = 0; done_cnt = 0; parked = 1'b0;
    start_i = 1'b1;
    @(negedge byte_clk_i);
    start_i = 1'b0;
    checkOutput("start_busy", busy_o, 1);
    checkOutput("start_clr_best", best_delay_o, 0);
    checkOutput("start_clr_eye", eye_width_o, 0);
    checkOutput("start_clr_fail", fail_o, 0);
    cycles = 1;
    while (busy_o && cycles < 20000) begin
      @(negedge byte_clk_i);
      cycles++;
    end
    if (busy_o) checkOutput("calib_timeout", 1, 0);
    @(negedge byte_clk_i);
    exp_pulses = (32 - start_tap) % 32 + 32 + ctr;
    checkOutput("park_pulses", park_cnt, (32 - start_tap) % 32);
    checkOutput("total_pulses", pulse_cnt, exp_pulses);
    checkOutput("done_count", done_cnt, exp_fail ? 0 : 1);
    checkOutput("fail_flag", fail_o, int'(exp_fail));
    checkOutput("best_delay", best_delay_o, exp_best);
    checkOutput("eye_width", eye_width_o, exp_eye);
    checkOutput("final_tap", tap, ctr);
  endtask

  initial begin
    int s, l, c1, c2, n, snap;
    rst_i   = 1'b1;
    start_i = 1'b0;
    repeat (3) @(negedge byte_clk_i);
    checkOutput("rst_inc", inc_delay_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_fail", fail_o, 0);
    checkOutput("rst_best", best_delay_o, 0);
    checkOutput("rst_eye", eye_width_o, 0);
    rst_i    = 1'b0;
    load_tap = 1'b0;
    @(negedge byte_clk_i);

    model_eye(MASK_A, s, l);
    checkOutput("model_a_start", s, 10);
    checkOutput("model_a_len", l, 10);
    model_eye(MASK_B, s, l);
    checkOutput("model_b_start", s, 2);
    model_eye(MASK_C, s, l);
    checkOutput("model_c_len", l, 2);
    model_eye(MASK_D, s, l);
    checkOutput("model_d_len", l, 32);

    $display("[TB] eye 10..19 from tap 5");
    applyStimulus(MASK_A, 1'b0, 5, c1);
    checkOutput("a_best_lit", best_delay_o, 15);
    checkOutput("a_eye_lit", eye_width_o, 10);
    checkOutput("a_park_lit", park_cnt, 27);
    checkOutput("a_total_lit", pulse_cnt, 74);

    $display("[TB] tied runs 2..5 and 20..23");
    applyStimulus(MASK_B, 1'b0, -1, c1);
    checkOutput("b_best_lit", best_delay_o, 4);
    checkOutput("b_eye_lit", eye_width_o, 4);

    $display("[TB] edge-only taps, no wrap");
    applyStimulus(MASK_C, 1'b0, -1, c1);
    checkOutput("c_fail_lit", fail_o, 1);
    checkOutput("c_eye_lit", eye_width_o, 2);

    $display("[TB] all taps pass");
    applyStimulus(MASK_D, 1'b0, -1, c1);
    checkOutput("d_best_lit", best_delay_o, 16);
    checkOutput("d_eye_lit", eye_width_o, 32);

    $display("[TB] continuous vs 50%% valid");
    applyStimulus(MASK_A, 1'b0, 0, c1);
    applyStimulus(MASK_A, 1'b1, 0, c2);
    checkOutput("toggle_best_lit", best_delay_o, 15);
    checkOutput("toggle_slowdown", int'((c2 - c1 >= 32 * 14) && (c2 - c1 <= 32 * 17)), 1);
    toggle_valid = 1'b0;

    $display("[TB] reset during sampling at tap 12");
    pass_mask = MASK_A;
    @(negedge byte_clk_i);
    start_i = 1'b1;
    @(negedge byte_clk_i);
    start_i = 1'b0;
    n = 0;
    while (tap != 5'd12 && n < 5000) begin
      @(negedge byte_clk_i);
      n++;
    end
    checkOutput("reach_tap12", int'(tap == 5'd12), 1);
    repeat (TB_SETTLE + 3) @(negedge byte_clk_i);
    rst_i = 1'b1;
    @(negedge byte_clk_i);
    rst_i = 1'b0;
    checkOutput("abort_busy", busy_o, 0);
    checkOutput("abort_fail", fail_o, 0);
    snap = pulse_cnt;
    repeat (40) @(negedge byte_clk_i);
    checkOutput("abort_no_inc", pulse_cnt, snap);
    checkOutput("abort_tap_held", tap, 12);
    applyStimulus(MASK_A, 1'b0, -1, c1);
    checkOutput("restart_total_lit", pulse_cnt, 67);
    checkOutput("restart_best_lit", best_delay_o, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
